// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: synchronises rx_in, finds the start edge and
// samples start/data/parity/stop at mid-bit from an oversampling baud tick.
module uart_rx_frame_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx_in,
    input  logic       rx_en,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       start_bit,
    output logic       parity_bit,
    output logic       stop_bit,
    output logic       received_flag,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             rx_s1, rx_s2, rx_d;
    logic             fall;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [1:0]       type_q;
    logic             has_par;
    logic             start_s, par_s;

    logic             type_ld, cnt_clr, cnt_inc, bit_clr, bit_inc;
    logic             start_cap, shift_en, par_cap, out_ld;

    assign fall    = rx_d & ~rx_s2;
    assign has_par = (type_q == 2'b01) || (type_q == 2'b10);

    // Line synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        type_ld       = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        bit_clr       = 1'b0;
        bit_inc       = 1'b0;
        start_cap     = 1'b0;
        shift_en      = 1'b0;
        par_cap       = 1'b0;
        out_ld        = 1'b0;
        received_flag = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (fall && rx_en) begin
                    state_d = START;
                    type_ld = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == HALF_M1) begin
                        if (rx_s2) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            start_cap = 1'b1;
                            cnt_clr   = 1'b1;
                            bit_clr   = 1'b1;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt == FULL_M1) begin
                        shift_en = 1'b1;
                        cnt_clr  = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state_d = has_par ? PARITY : STOP;
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt == FULL_M1) begin
                        par_cap = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = STOP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == FULL_M1) begin
                        out_ld  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                received_flag = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            type_q   <= '0;
            start_s  <= 1'b0;
            par_s    <= 1'b0;
        end else begin
            if (cnt_clr) begin
                tick_cnt <= '0;
            end else if (cnt_inc) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Parity sample defaults to 0 so frames without a parity slot report 0
            if (type_ld) begin
                type_q <= parity_type;
                par_s  <= 1'b0;
            end else if (par_cap) begin
                par_s <= rx_s2;
            end
            if (start_cap) begin
                start_s <= rx_s2;
            end
            if (shift_en) begin
                shift_q <= {rx_s2, shift_q[7:1]};
            end
        end
    end

    // Visible fields change only on the edge entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            start_bit  <= 1'b0;
            parity_bit <= 1'b0;
            stop_bit   <= 1'b0;
        end else if (out_ld) begin
            data_out   <= shift_q;
            start_bit  <= start_s;
            parity_bit <= par_s;
            stop_bit   <= rx_s2;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frames are driven bit-by-bit against a
// baud tick every 8 clks (16 ticks per bit) and checked against hand values.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       rx_in;
    logic       rx_en;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       start_bit;
    logic       parity_bit;
    logic       stop_bit;
    logic       received_flag;
    logic       busy;

    int         tests_run = 0;
    int         fails = 0;
    int         tick_total = 0;
    int         flag_cnt = 0;
    int         flag_tick = 0;
    int         busy_cyc = 0;
    int         phase = 0;
    int         t_start = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] held_data = 8'h00;

    uart_rx_frame_ctrl #(.OVERSAMPLE(16), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx_in        (rx_in),
        .rx_en        (rx_en),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .start_bit    (start_bit),
        .parity_bit   (parity_bit),
        .stop_bit     (stop_bit),
        .received_flag(received_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            phase     = (phase + 1) % 8;
            baud_tick = (phase == 0);
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_total++;
    end

    // held_data is the field value in the cycle just before each flag
    always @(negedge clk) begin
        if (received_flag) begin
            flag_cnt++;
            flag_tick = tick_total;
            held_data = prev_data;
        end
        prev_data = data_out;
        if (busy) busy_cyc++;
    end

    task wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task drive_bit(input logic v);
        @(negedge clk);
        rx_in = v;
    endtask

    task bit_period(input logic v);
        drive_bit(v);
        wait_ticks(16);
    endtask

    task go_idle(input int n);
        drive_bit(1'b1);
        wait_ticks(n);
    endtask

    task send_frame(input logic [7:0] d, input logic has_par, input logic par, input logic stp);
        drive_bit(1'b0);
        t_start = tick_total;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
        if (has_par) bit_period(par);
        bit_period(stp);
    endtask

    task test_reset;
        rst = 1'b1;
        rx_in = 1'b1;
        rx_en = 1'b1;
        parity_type = 2'b00;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({data_out, start_bit, parity_bit, stop_bit, received_flag, busy} !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got data=%h st=%b par=%b sp=%b flag=%b busy=%b required all 0",
                     data_out, start_bit, parity_bit, stop_bit, received_flag, busy);
        end
        rst = 1'b0;
    endtask

    task test_even_frame;
        int f0;
        parity_type = 2'b10;
        go_idle(4);
        f0 = flag_cnt;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        go_idle(4);
        tests_run++;
        if (flag_cnt !== f0 + 1) begin
            fails++; $display("FAIL even_flag_count: got %0d required %0d", flag_cnt - f0, 1);
        end
        tests_run++;
        if (data_out !== 8'h5A) begin
            fails++; $display("FAIL even_data: got %h required 5a", data_out);
        end
        tests_run++;
        if ({start_bit, parity_bit, stop_bit} !== 3'b001) begin
            fails++; $display("FAIL even_bits: got st/par/sp=%b%b%b required 001", start_bit, parity_bit, stop_bit);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL even_busy_after: got %b required 0", busy);
        end
    endtask

    task test_no_parity;
        int f0;
        int lat;
        parity_type = 2'b00;
        go_idle(4);
        f0 = flag_cnt;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        go_idle(4);
        lat = flag_tick - t_start;
        tests_run++;
        if (flag_cnt !== f0 + 1) begin
            fails++; $display("FAIL nopar_flag_count: got %0d required 1", flag_cnt - f0);
        end
        // Flag follows the mid-stop sample: 8 + 8*16 + 16 ticks after the start edge
        tests_run++;
        if (lat < 151 || lat > 153) begin
            fails++; $display("FAIL nopar_latency: got %0d ticks required 152 +/-1", lat);
        end
        tests_run++;
        if (data_out !== 8'hC3) begin
            fails++; $display("FAIL nopar_data: got %h required c3", data_out);
        end
        tests_run++;
        if ({parity_bit, stop_bit} !== 2'b01) begin
            fails++; $display("FAIL nopar_bits: got par/sp=%b%b required 01", parity_bit, stop_bit);
        end
    endtask

    task test_glitch;
        int f0;
        int b0;
        int bw;
        logic [10:0] fields0;
        go_idle(4);
        f0 = flag_cnt;
        b0 = busy_cyc;
        fields0 = {data_out, start_bit, parity_bit, stop_bit};
        drive_bit(1'b0);
        wait_ticks(3);
        go_idle(12);
        bw = busy_cyc - b0;
        tests_run++;
        if (flag_cnt !== f0) begin
            fails++; $display("FAIL glitch_no_flag: got %0d flags required 0", flag_cnt - f0);
        end
        tests_run++;
        if (bw <= 0 || bw >= 64) begin
            fails++; $display("FAIL glitch_busy_width: got %0d clks required 1..63", bw);
        end
        tests_run++;
        if ({data_out, start_bit, parity_bit, stop_bit} !== fields0 || busy !== 1'b0) begin
            fails++; $display("FAIL glitch_unchanged: got %h busy=%b required %h busy=0",
                              {data_out, start_bit, parity_bit, stop_bit}, busy, fields0);
        end
    endtask

    task test_break;
        int f0;
        parity_type = 2'b01;
        go_idle(4);
        f0 = flag_cnt;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        wait_ticks(40 * 16);
        tests_run++;
        if (flag_cnt !== f0 + 1) begin
            fails++; $display("FAIL break_flag_count: got %0d required 1", flag_cnt - f0);
        end
        tests_run++;
        if ({data_out, parity_bit, stop_bit} !== {8'h01, 1'b0, 1'b0}) begin
            fails++; $display("FAIL break_fields: got data=%h par=%b sp=%b required 01 0 0",
                              data_out, parity_bit, stop_bit);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL break_no_retrigger: got busy=%b required 0", busy);
        end
        go_idle(32);
        tests_run++;
        if (flag_cnt !== f0 + 1 || busy !== 1'b0) begin
            fails++; $display("FAIL break_release: got %0d flags busy=%b required 1 flag busy=0",
                              flag_cnt - f0, busy);
        end
    endtask

    task test_reset_midframe;
        int f0;
        parity_type = 2'b00;
        go_idle(4);
        f0 = flag_cnt;
        drive_bit(1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) bit_period(1'b1);
        drive_bit(1'b1);
        wait_ticks(8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({data_out, start_bit, parity_bit, stop_bit, received_flag, busy} !== 13'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got data=%h st=%b par=%b sp=%b flag=%b busy=%b required all 0",
                     data_out, start_bit, parity_bit, stop_bit, received_flag, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        parity_type = 2'b01;
        go_idle(32);
        tests_run++;
        if (flag_cnt !== f0) begin
            fails++; $display("FAIL midreset_no_flag: got %0d flags required 0", flag_cnt - f0);
        end
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        go_idle(4);
        tests_run++;
        if (flag_cnt !== f0 + 1 || data_out !== 8'hA5) begin
            fails++; $display("FAIL midreset_next_frame: got %0d flags data=%h required 1 flag data=a5",
                              flag_cnt - f0, data_out);
        end
        tests_run++;
        if ({start_bit, parity_bit, stop_bit} !== 3'b011) begin
            fails++; $display("FAIL midreset_bits: got st/par/sp=%b%b%b required 011", start_bit, parity_bit, stop_bit);
        end
    endtask

    task test_back_to_back;
        int f0;
        parity_type = 2'b10;
        go_idle(4);
        f0 = flag_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (flag_cnt !== f0 + 1 || data_out !== 8'h11) begin
            fails++; $display("FAIL b2b_first: got %0d flags data=%h required 1 flag data=11",
                              flag_cnt - f0, data_out);
        end
        send_frame(8'hEE, 1'b1, 1'b0, 1'b1);
        go_idle(4);
        tests_run++;
        if (flag_cnt !== f0 + 2) begin
            fails++; $display("FAIL b2b_flag_count: got %0d required 2", flag_cnt - f0);
        end
        tests_run++;
        if (held_data !== 8'h11) begin
            fails++; $display("FAIL b2b_hold: got %h before second flag required 11", held_data);
        end
        tests_run++;
        if (data_out !== 8'hEE || stop_bit !== 1'b1) begin
            fails++; $display("FAIL b2b_second: got data=%h sp=%b required ee 1", data_out, stop_bit);
        end
    endtask

    initial begin
        test_reset();
        test_even_frame();
        test_no_parity();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
